// File: rtl/calc_accumulator_if.sv
// Control-block to accumulator connection: toggle-encoded events, digit entry
// and the displayed result.
interface calc_accumulator_if;
    logic        store;
    logic        update;
    logic        show;
    logic        clr;
    logic        digit_valid;
    logic [3:0]  digit;
    logic [13:0] disp_val;
    logic        acc_valid;
    logic        err;

    modport master (
        output store, update, show, clr, digit_valid, digit,
        input  disp_val, acc_valid, err
    );

    modport slave (
        input  store, update, show, clr, digit_valid, digit,
        output disp_val, acc_valid, err
    );
endinterface

// File: rtl/calc_accumulator.sv
// BCD-entry decimal accumulator (0..9999) driven by toggle-encoded events from
// a control block in another clock domain; overflow is sticky until clr/reset.
module calc_accumulator (
    input  logic              clk,
    input  logic              reset_n,
    calc_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACC   = 2'd1,
        ERR   = 2'd2
    } state_t;

    localparam logic [16:0] DIGIT_LIMIT = 17'd9999;
    localparam logic [14:0] SUM_LIMIT   = 15'd9999;

    // Bit order in the toggle pipelines: [0]=store, [1]=update, [2]=show.
    logic [2:0]  tog_s1;
    logic [2:0]  tog_s2;
    logic [2:0]  tog_s3;
    logic [2:0]  tog_ev;
    logic        clr_s1;
    logic        clr_s2;

    state_t      state;
    logic [13:0] operand;
    logic [13:0] accum;
    logic        disp_sel;
    logic        acc_valid_q;
    logic        err_q;

    logic        store_ev;
    logic        update_ev;
    logic        show_ev;
    logic [16:0] digit_next;
    logic        digit_ok;
    logic [14:0] sum;
    logic        sum_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tog_s1 <= '0;
            tog_s2 <= '0;
            tog_s3 <= '0;
            clr_s1 <= 1'b0;
            clr_s2 <= 1'b0;
        end else begin
            tog_s1 <= {bus.show, bus.update, bus.store};
            tog_s2 <= tog_s1;
            tog_s3 <= tog_s2;
            clr_s1 <= bus.clr;
            clr_s2 <= clr_s1;
        end
    end

    assign tog_ev    = tog_s2 ^ tog_s3;
    assign store_ev  = tog_ev[0];
    assign update_ev = tog_ev[1];
    assign show_ev   = tog_ev[2];

    always_comb begin
        digit_next = ({3'b000, operand} * 17'd10) + {13'd0, bus.digit};
        digit_ok   = bus.digit_valid && (bus.digit <= 4'd9) && (digit_next <= DIGIT_LIMIT);
        sum        = {1'b0, accum} + {1'b0, operand};
        sum_ok     = (sum <= SUM_LIMIT);
    end

    // A store/update only pre-empts digit entry when it actually takes effect
    // in the current state; an ignored event leaves the digit path free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= EMPTY;
            operand     <= '0;
            accum       <= '0;
            disp_sel    <= 1'b0;
            acc_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (clr_s2) begin
            state       <= EMPTY;
            operand     <= '0;
            accum       <= '0;
            disp_sel    <= 1'b0;
            acc_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (show_ev) begin
                disp_sel <= ~disp_sel;
            end
            case (state)
                EMPTY: begin
                    if (store_ev) begin
                        accum       <= operand;
                        operand     <= '0;
                        state       <= ACC;
                        acc_valid_q <= 1'b1;
                    end else if (digit_ok) begin
                        operand <= digit_next[13:0];
                    end
                end
                ACC: begin
                    if (store_ev) begin
                        accum   <= operand;
                        operand <= '0;
                    end else if (update_ev) begin
                        operand <= '0;
                        if (sum_ok) begin
                            accum <= sum[13:0];
                        end else begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end
                    end else if (digit_ok) begin
                        operand <= digit_next[13:0];
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state       <= EMPTY;
                    operand     <= '0;
                    accum       <= '0;
                    acc_valid_q <= 1'b0;
                    err_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.disp_val  = disp_sel ? accum : operand;
    assign bus.acc_valid = acc_valid_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_calc_accumulator.sv
// Directed bench for calc_accumulator: digit entry, toggle events, overflow,
// same-cycle priority and asynchronous reset.
module tb_calc_accumulator;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    calc_accumulator_if bus ();

    calc_accumulator dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic enter(input logic [3:0] d);
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        tick(1);
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
    endtask

    task automatic clr_pulse();
        bus.clr = 1'b1;
        tick(1);
        bus.clr = 1'b0;
        tick(4);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset_n         = 1'b0;
        bus.store       = 1'b0;
        bus.update      = 1'b0;
        bus.show        = 1'b0;
        bus.clr         = 1'b0;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        tick(3);
        check("reset_disp", bus.disp_val, 14'd0);
        check("reset_accv", {13'd0, bus.acc_valid}, 14'd0);
        check("reset_err", {13'd0, bus.err}, 14'd0);
        reset_n = 1'b1;
        tick(2);

        // Digit entry and invalid digit
        enter(4'd1);
        enter(4'd2);
        enter(4'd3);
        check("digits_123", bus.disp_val, 14'd123);
        enter(4'hA);
        check("digit_A_ignored", bus.disp_val, 14'd123);
        clr_pulse();
        check("clr_operand", bus.disp_val, 14'd0);

        // 45 + 55 with three-edge event latency
        enter(4'd4);
        enter(4'd5);
        bus.store = ~bus.store;
        tick(2);
        check("store_not_yet", {13'd0, bus.acc_valid}, 14'd0);
        check("store_not_yet_disp", bus.disp_val, 14'd45);
        tick(1);
        check("store_accv", {13'd0, bus.acc_valid}, 14'd1);
        check("store_clears_op", bus.disp_val, 14'd0);
        enter(4'd5);
        enter(4'd5);
        check("op_55", bus.disp_val, 14'd55);
        bus.update = ~bus.update;
        tick(3);
        check("update_clears_op", bus.disp_val, 14'd0);
        bus.show = ~bus.show;
        tick(2);
        check("show_not_yet", bus.disp_val, 14'd0);
        tick(1);
        check("sum_100", bus.disp_val, 14'd100);
        check("sum_accv", {13'd0, bus.acc_valid}, 14'd1);
        check("sum_err", {13'd0, bus.err}, 14'd0);

        // Overflow: 9000 + 1000
        enter(4'd9); enter(4'd0); enter(4'd0); enter(4'd0);
        bus.store = ~bus.store;
        tick(3);
        check("acc_9000", bus.disp_val, 14'd9000);
        enter(4'd1); enter(4'd0); enter(4'd0); enter(4'd0);
        bus.show = ~bus.show;
        tick(3);
        check("op_1000", bus.disp_val, 14'd1000);
        bus.update = ~bus.update;
        tick(3);
        check("ovf_err", {13'd0, bus.err}, 14'd1);
        check("ovf_accv", {13'd0, bus.acc_valid}, 14'd1);
        check("ovf_op_cleared", bus.disp_val, 14'd0);
        bus.show = ~bus.show;
        tick(3);
        check("ovf_acc_kept", bus.disp_val, 14'd9000);
        enter(4'd5);
        bus.store = ~bus.store;
        tick(3);
        bus.show = ~bus.show;
        tick(3);
        check("err_digit_ignored", bus.disp_val, 14'd0);
        check("err_sticky", {13'd0, bus.err}, 14'd1);
        bus.show = ~bus.show;
        tick(3);
        check("err_store_ignored", bus.disp_val, 14'd9000);
        clr_pulse();
        check("clr_disp", bus.disp_val, 14'd0);
        check("clr_err", {13'd0, bus.err}, 14'd0);
        check("clr_accv", {13'd0, bus.acc_valid}, 14'd0);

        // Same-cycle store and update: store wins
        enter(4'd3);
        bus.store = ~bus.store;
        tick(3);
        enter(4'd7);
        check("op_7", bus.disp_val, 14'd7);
        bus.store  = ~bus.store;
        bus.update = ~bus.update;
        tick(3);
        check("both_op_cleared", bus.disp_val, 14'd0);
        bus.show = ~bus.show;
        tick(3);
        check("store_wins", bus.disp_val, 14'd7);
        tick(2);
        check("update_dropped", bus.disp_val, 14'd7);

        // Exact 9999 sum is not an overflow
        enter(4'd9); enter(4'd9); enter(4'd9); enter(4'd2);
        bus.update = ~bus.update;
        tick(3);
        check("sum_9999", bus.disp_val, 14'd9999);
        check("sum_9999_err", {13'd0, bus.err}, 14'd0);
        clr_pulse();

        // Digit limit and update in EMPTY
        enter(4'd9); enter(4'd9); enter(4'd9); enter(4'd9);
        check("op_9999", bus.disp_val, 14'd9999);
        enter(4'd5);
        check("fifth_ignored", bus.disp_val, 14'd9999);
        bus.update = ~bus.update;
        tick(3);
        check("empty_update_disp", bus.disp_val, 14'd9999);
        check("empty_update_accv", {13'd0, bus.acc_valid}, 14'd0);
        bus.store = ~bus.store;
        tick(3);
        check("store_from_empty", {13'd0, bus.acc_valid}, 14'd1);
        enter(4'd4);
        enter(4'd2);
        check("op_42", bus.disp_val, 14'd42);

        // Asynchronous reset between edges
        #2;
        reset_n    = 1'b0;
        bus.store  = 1'b0;
        bus.update = 1'b0;
        bus.show   = 1'b0;
        #1;
        check("async_disp", bus.disp_val, 14'd0);
        check("async_accv", {13'd0, bus.acc_valid}, 14'd0);
        check("async_err", {13'd0, bus.err}, 14'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(4);
        check("post_reset_disp", bus.disp_val, 14'd0);
        check("post_reset_accv", {13'd0, bus.acc_valid}, 14'd0);
        enter(4'd6);
        bus.store = ~bus.store;
        tick(3);
        check("post_reset_store", {13'd0, bus.acc_valid}, 14'd1);
        bus.show = ~bus.show;
        tick(3);
        check("post_reset_acc", bus.disp_val, 14'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
